// File: rtl/waveform_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// wfm_uart_pkg
// Shared constants and types for the waveform UART transmitter.
//   - Waveform geometry (SAMPLES x SAMPLE_W) and the frame header byte.
//   - Frame length for both builds. The macro WFM_UART_CHECKSUM_EN selects
//     the checksum build, which appends one XOR byte after the samples.
//   - state_t: top-level frame FSM encoding.
//   - sample_byte(): splits a sample into its high/low transmitted bytes.
// ---------------------------------------------------------------------------
package wfm_uart_pkg;

    localparam int SAMPLES  = 64;
    localparam int SAMPLE_W = 14;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    localparam int FRAME_BYTES_PLAIN = 1 + 2 * SAMPLES;        // 129
    localparam int FRAME_BYTES_CSUM  = FRAME_BYTES_PLAIN + 1;  // 130

`ifdef WFM_UART_CHECKSUM_EN
    localparam int FRAME_BYTES = FRAME_BYTES_CSUM;
`else
    localparam int FRAME_BYTES = FRAME_BYTES_PLAIN;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        LOAD = 2'd2,
        SEND = 2'd3
    } state_t;

    // High byte carries the top 6 bits zero-extended, low byte the bottom 8.
    function automatic logic [7:0] sample_byte(input logic [SAMPLE_W-1:0] s,
                                               input logic hi);
        return hi ? {2'b00, s[13:8]} : s[7:0];
    endfunction

endpackage

// File: rtl/waveform_uart_tx_if.sv
// ---------------------------------------------------------------------------
// waveform_uart_tx_if
// Bundles the capture-side inputs and UART-side outputs of waveform_uart_tx.
//   trigger_in  : trigger shared with the capture stage
//   waveform    : 64 x 14-bit sample array, index 0 = first sample
//   tx          : UART serial line, idle high
//   busy        : high from accepted trigger to end of last stop bit
//   frame_done  : one-cycle pulse after the final stop bit
//   dbg_state   : current frame FSM state, for observation only
// master = capture side / environment, slave = the transmitter.
// ---------------------------------------------------------------------------
interface waveform_uart_tx_if;
    import wfm_uart_pkg::*;

    logic                trigger_in;
    logic [SAMPLE_W-1:0] waveform [SAMPLES];
    logic                tx;
    logic                busy;
    logic                frame_done;
    state_t              dbg_state;

    modport master (
        output trigger_in,
        output waveform,
        input  tx,
        input  busy,
        input  frame_done,
        input  dbg_state
    );

    modport slave (
        input  trigger_in,
        input  waveform,
        output tx,
        output busy,
        output frame_done,
        output dbg_state
    );
endinterface

// File: rtl/waveform_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// 8N1 bit serialiser. Owns the baud counter and the bit index.
//   clk, rst_n : clock, synchronous active-low reset
//   data       : byte to send, taken when valid && ready
//   valid      : producer has a byte
//   ready      : serialiser can take a byte this cycle
//   tx         : serial line (start 0, 8 data LSB first, stop 1)
// Handshake: a byte is transferred on a rising edge where valid && ready are
// both high; data must be stable while valid is high and not yet accepted.
// ready is also high during the final cycle of a stop bit so the next start
// bit follows the stop bit with no idle gap.
// ---------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;   // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]       r_data;
    logic             r_tx;
    logic             w_last;

    assign w_last = r_active && (r_cnt == CNT_LAST) && (r_bit == 4'd9);
    assign ready  = !r_active || w_last;
    assign tx     = r_tx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_data   <= '0;
            r_tx     <= 1'b1;
        end else if (valid && ready) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_data   <= data;
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    // Leaving bit n selects data[n]; leaving data bit 7 selects stop.
                    r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_data[r_bit[2:0]];
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/waveform_uart_tx.sv
// ---------------------------------------------------------------------------
// waveform_uart_tx
// Follows the capture-stage trigger, snapshots the 64-sample waveform once
// capture has finished, and sends it as a framed byte stream over 8N1 UART:
// 0xA5, then per sample {2'b00,s[13:8]}, s[7:0].
// Optional feature macro: WFM_UART_CHECKSUM_EN appends the XOR of all 128
// data bytes (header excluded) as a final byte.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : waveform_uart_tx_if.slave (trigger_in, waveform, tx, busy,
//                frame_done, dbg_state)
// Triggers seen while a frame is in progress are dropped.
// ---------------------------------------------------------------------------
module waveform_uart_tx
    import wfm_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic               clk,
    input  logic               rst_n,
    waveform_uart_tx_if.slave  bus
);
    localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES);

    state_t              r_state;
    state_t              w_next;
    logic [5:0]          r_arm_cnt;
    logic [7:0]          r_idx;
    logic                r_done;
    logic [SAMPLE_W-1:0] r_shadow [SAMPLES];
    logic [7:0]          w_byte;
    logic [6:0]          w_sidx;
    logic                w_valid;
    logic                w_ready;
    logic                w_fire;
    logic                w_tx;
`ifdef WFM_UART_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    assign w_valid = (r_state == SEND) && (r_idx != LAST_IDX);
    assign w_fire  = w_valid && w_ready;

    // Next-state logic. ARM counter reaches 62 on the edge T0+62, so the
    // move to LOAD happens at T0+63 after the last sample has been written.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.trigger_in) w_next = ARM;
            ARM:  if (r_arm_cnt == 6'd62) w_next = LOAD;
            LOAD: w_next = SEND;
            SEND: if (r_idx == LAST_IDX && w_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Byte mux: index 0 is the header, 1..128 are sample bytes (odd = high).
    always_comb begin
        w_sidx = 7'(r_idx - 8'd1);
        w_byte = HEADER_BYTE;
        if (r_idx != 8'd0) begin
            w_byte = sample_byte(r_shadow[w_sidx[6:1]], ~w_sidx[0]);
        end
`ifdef WFM_UART_CHECKSUM_EN
        if (r_idx == 8'(FRAME_BYTES_PLAIN)) begin
            w_byte = r_csum;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_arm_cnt <= '0;
            r_idx     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == SEND) && (w_next == IDLE);
            case (r_state)
                IDLE: begin
                    if (bus.trigger_in) begin
                        r_arm_cnt <= '0;
                        r_idx     <= '0;
                    end
                end
                ARM:  r_arm_cnt <= r_arm_cnt + 6'd1;
                SEND: if (w_fire) r_idx <= r_idx + 8'd1;
                default: ;
            endcase
        end
    end

`ifdef WFM_UART_CHECKSUM_EN
    // Accumulates sample bytes only; the checksum byte itself is sent last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (r_state == IDLE && bus.trigger_in) begin
            r_csum <= '0;
        end else if (w_fire && r_idx != 8'd0 && r_idx != 8'(FRAME_BYTES_PLAIN)) begin
            r_csum <= r_csum ^ w_byte;
        end
    end
`endif

    // Shadow copy taken once in LOAD; the capture stage is free afterwards.
    always_ff @(posedge clk) begin
        if (rst_n && r_state == LOAD) begin
            for (int i = 0; i < SAMPLES; i++) begin
                r_shadow[i] <= bus.waveform[i];
            end
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (w_byte),
        .valid (w_valid),
        .ready (w_ready),
        .tx    (w_tx)
    );

    assign bus.tx         = w_tx;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = r_done;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_waveform_uart_tx.sv
module tb_waveform_uart_tx;
    import wfm_uart_pkg::*;

    localparam int C = 4;

    typedef struct {
        int         kind;       // 0 ramp, 1 fill all, 2 single sample 0, 3 random
        logic [13:0] fill;
        int         retrig_a;   // cycle offset from T0 where an extra trigger is sampled
        int         retrig_b;
        int         change_at;  // offset where the capture array is overwritten with 0x2AAA
        int         rst_byte;   // byte index for mid-frame reset, -1 = none
        bit         chain;      // retrigger on the first cycle busy is low
        bit         csum_known;
        logic [7:0] exp_csum;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    logic [7:0] exp_q[$];
    vec_t vecs[9];

    waveform_uart_tx_if bus();

    waveform_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Builds the expected byte list for a frame directly from the sample values.
    task automatic build_expected(input logic [13:0] s[64], input vec_t v);
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        x = 8'h00;
        for (int i = 0; i < 64; i++) begin
            hi = {2'b00, s[i][13:8]};
            lo = s[i][7:0];
            exp_q.push_back(hi);
            exp_q.push_back(lo);
            x = x ^ hi ^ lo;
        end
`ifdef WFM_UART_CHECKSUM_EN
        exp_q.push_back(v.csum_known ? v.exp_csum : x);
`endif
    endtask

    task automatic run_frame(input int vi, input bit pretrig);
        vec_t        v;
        logic [13:0] s[64];
        logic [7:0]  rx[130];
        bit          glitch[130];
        logic [7:0]  eb;
        int nb, endt, stop_t, last_t, nb_cmp, u, b, c;
        int line_err, busy_err, done_err;
        logic etx, ebusy, edone;

        v = vecs[vi];
        for (int i = 0; i < 64; i++) begin
            case (v.kind)
                0: s[i] = 14'(i);
                1: s[i] = v.fill;
                2: s[i] = (i == 0) ? v.fill : 14'h0;
                default: s[i] = 14'($urandom_range(0, 16383));
            endcase
        end
        build_expected(s, v);
        nb     = exp_q.size();
        endt   = 65 + nb * 10 * C;
        stop_t = (v.rst_byte >= 0) ? 65 + v.rst_byte * 10 * C + 4 * C + 1 : -1;
        last_t = (stop_t >= 0) ? stop_t + 40 : (v.chain ? endt : endt + 3);
        nb_cmp = (stop_t >= 0) ? (stop_t - 65) / (10 * C) : nb;
        for (int i = 0; i < 130; i++) begin
            rx[i] = 8'h00;
            glitch[i] = 1'b0;
        end
        line_err = 0; busy_err = 0; done_err = 0;

        // Stale contents that must never reach the line.
        for (int i = 0; i < 64; i++) bus.waveform[i] = 14'h1555;
        if (!pretrig) begin
            @(negedge clk);
            bus.trigger_in = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.trigger_in = 1'b0;

        for (int t = 0; t <= last_t; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (stop_t >= 0 && t > stop_t) begin
                etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
                if (bus.tx !== etx) line_err++;
            end else begin
                ebusy = (t < endt);
                edone = (t == endt);
                if (t >= 65 && t < endt) begin
                    u  = t - 65;
                    b  = u / (10 * C);
                    c  = (u % (10 * C)) / C;
                    eb = exp_q[b];
                    etx = (c == 0) ? 1'b0 : (c == 9) ? 1'b1 : eb[c-1];
                    if (bus.tx !== etx) glitch[b] = 1'b1;
                    if ((u % C) == C / 2 && c >= 1 && c <= 8) rx[b][c-1] = bus.tx;
                end else begin
                    etx = 1'b1;
                    if (bus.tx !== etx) line_err++;
                end
            end
            if (bus.busy !== ebusy) busy_err++;
            if (bus.frame_done !== edone) done_err++;

            // Drive for the next edge: capture writes, extra triggers, reset.
            if (t < 64) bus.waveform[t] = s[t];
            if (t == v.change_at) for (int i = 0; i < 64; i++) bus.waveform[i] = 14'h2AAA;
            bus.trigger_in = (t + 1 == v.retrig_a) || (t + 1 == v.retrig_b) ||
                             (v.chain && t == endt);
            if (t == stop_t) rst_n = 1'b0;
            if (t == stop_t + 1) rst_n = 1'b1;
        end

        check($sformatf("f%0d_line_idle", vi), 32'(line_err), 32'd0);
        check($sformatf("f%0d_busy", vi), 32'(busy_err), 32'd0);
        check($sformatf("f%0d_frame_done", vi), 32'(done_err), 32'd0);
        for (int i = 0; i < nb_cmp; i++) begin
            check($sformatf("f%0d_byte%0d", vi, i), {23'd0, glitch[i], rx[i]}, {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        int bad_rst;
        n_total = 0;
        n_bad   = 0;

        //            kind fill     ra   rb   chg rst chain known csum
        vecs[0] = '{0, 14'h0000, -1,  -1,  -1, -1, 0, 0, 8'h00};
        vecs[1] = '{1, 14'h3FFF, -1,  -1,  -1, -1, 0, 1, 8'h00};
        vecs[2] = '{1, 14'h0001, -1,  -1,  -1, -1, 0, 1, 8'h00};
        vecs[3] = '{2, 14'h0155, -1,  -1,  -1, -1, 0, 1, 8'h54};
        vecs[4] = '{0, 14'h0000, 70,  200, -1, -1, 1, 0, 8'h00};
        vecs[5] = '{3, 14'h0000, -1,  -1,  -1, -1, 0, 0, 8'h00};
        vecs[6] = '{0, 14'h0000, -1,  -1,  66, -1, 0, 0, 8'h00};
        vecs[7] = '{0, 14'h0000, -1,  -1,  -1, 40, 0, 0, 8'h00};
        vecs[8] = '{3, 14'h0000, -1,  -1,  -1, -1, 0, 0, 8'h00};

        // Reset held with a toggling trigger: line idle, no activity.
        rst_n = 1'b0;
        bus.trigger_in = 1'b0;
        for (int i = 0; i < 64; i++) bus.waveform[i] = 14'h0;
        bad_rst = 0;
        for (int i = 0; i < 20; i++) begin
            bus.trigger_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) bad_rst++;
        end
        check("reset_hold", 32'(bad_rst), 32'd0);
        check("reset_state", 32'(bus.dbg_state), 32'(IDLE));
        bus.trigger_in = 1'b0;
        rst_n = 1'b1;
        bad_rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad_rst++;
        end
        check("idle_after_reset", 32'(bad_rst), 32'd0);

        for (int vi = 0; vi < 9; vi++) begin
            run_frame(vi, (vi > 0) && vecs[vi-1].chain);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
